// File: rtl/pll_pkg.sv
// Shared types and constants for the PLL phase-control path.
package pll_pkg;

    // Reset divider of the DCO; the phase controller's shadow must start here too.
    localparam int unsigned DCO_DIV_INIT = 23;

    typedef enum logic [1:0] {
        StIdle,
        StTrack,
        StLocked
    } pll_state_e;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer for an asynchronous input, plus a one-cycle edge detector
// that fires on either polarity of the synchronized level.
module edge_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic sync_level,
    output logic edge_pulse
);

    logic s1_q, s2_q, s3_q;

    // s1/s2 resolve metastability; s3 is the previous synchronized level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= async_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign sync_level = s2_q;
    assign edge_pulse = s2_q ^ s3_q;

endmodule

// File: rtl/pll_phase_ctrl.sv
// Bang-bang phase detector and loop filter feeding the DCO with add/plus period
// corrections and a bothedge resync; keeps a shadow divider and reports lock.
module pll_phase_ctrl
    import pll_pkg::*;
#(
    parameter int unsigned DIV_INIT = DCO_DIV_INIT,
    parameter int unsigned DIV_MIN  = 8,
    parameter int unsigned DIV_MAX  = 64,
    parameter int unsigned K        = 4,
    parameter int unsigned LOCK_N   = 16,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        data_in,
    input  logic        pwm_clk,
    output logic        add,
    output logic        plus,
    output logic        bothedge,
    output logic        lock,
    output logic [15:0] div_est
);

    localparam int unsigned AccW  = $clog2(K) + 2;
    localparam int unsigned LockW = $clog2(LOCK_N + 1);
    localparam int unsigned ToW   = $clog2(TIMEOUT + 1);

    localparam logic signed [AccW-1:0] AccPos = AccW'(K);
    localparam logic signed [AccW-1:0] AccNeg = -AccPos;
    localparam logic [LockW-1:0]       LockMax = LockW'(LOCK_N);
    localparam logic [ToW-1:0]         ToLast  = ToW'(TIMEOUT - 1);
    localparam logic [15:0]            DivMin  = 16'(DIV_MIN);
    localparam logic [15:0]            DivMax  = 16'(DIV_MAX);

    logic data_edge;
    logic data_level_unused;

    edge_sync u_edge_sync (
        .clk        (clk),
        .reset_n    (reset_n),
        .async_in   (data_in),
        .sync_level (data_level_unused),
        .edge_pulse (data_edge)
    );

    pll_state_e               state_q, state_d;
    logic signed [AccW-1:0]   acc_q, acc_d, acc_vote;
    logic [LockW-1:0]         lock_cnt_q, lock_cnt_d;
    logic [ToW-1:0]           to_cnt_q, to_cnt_d;
    logic [15:0]              div_q, div_d;
    logic                     hist_valid_q, hist_valid_d;
    logic                     hist_up_q, hist_up_d;
    logic                     add_q, add_d, plus_q, plus_d, both_q, both_d, lock_q, lock_d;
    logic                     corr, corr_up, timeout_hit;

    // Early (pwm_clk low at the data edge) votes up, late votes down.
    assign acc_vote = pwm_clk ? (acc_q - AccW'(1)) : (acc_q + AccW'(1));

    // A data edge in the timeout cycle takes priority over the timeout.
    assign timeout_hit = (state_q != StIdle) && !data_edge && (to_cnt_q == ToLast);

    // Next-state, loop filter, lock/drift tracking and pulse generation.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        lock_cnt_d   = lock_cnt_q;
        div_d        = div_q;
        hist_valid_d = hist_valid_q;
        hist_up_d    = hist_up_q;
        add_d        = 1'b0;
        plus_d       = 1'b0;
        both_d       = 1'b0;
        corr         = 1'b0;
        corr_up      = 1'b0;

        if (data_edge) begin
            to_cnt_d = '0;
        end else if (state_q != StIdle) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end else begin
            to_cnt_d = '0;
        end

        unique case (state_q)
            StIdle: begin
                acc_d        = '0;
                lock_cnt_d   = '0;
                hist_valid_d = 1'b0;
                if (data_edge) begin
                    both_d  = 1'b1;
                    state_d = StTrack;
                end
            end
            StTrack, StLocked: begin
                if (data_edge) begin
                    if (acc_vote == AccPos) begin
                        corr    = 1'b1;
                        corr_up = 1'b1;
                        acc_d   = '0;
                        if (div_q != DivMax) begin
                            add_d = 1'b1;
                            div_d = div_q + 16'd1;
                        end
                    end else if (acc_vote == AccNeg) begin
                        corr  = 1'b1;
                        acc_d = '0;
                        if (div_q != DivMin) begin
                            plus_d = 1'b1;
                            div_d  = div_q - 16'd1;
                        end
                    end else begin
                        acc_d = acc_vote;
                    end

                    if (corr) begin
                        lock_cnt_d = '0;
                    end else if (lock_cnt_q != LockMax) begin
                        lock_cnt_d = lock_cnt_q + 1'b1;
                    end

                    if (state_q == StTrack) begin
                        if (!corr && (lock_cnt_d == LockMax)) begin
                            state_d      = StLocked;
                            hist_valid_d = 1'b0;
                        end
                    end else if (corr) begin
                        // Same direction twice in a row is drift; alternating is dither.
                        if (hist_valid_q && (hist_up_q == corr_up)) begin
                            state_d      = StTrack;
                            lock_cnt_d   = '0;
                            hist_valid_d = 1'b0;
                        end else begin
                            hist_valid_d = 1'b1;
                            hist_up_d    = corr_up;
                        end
                    end
                end else if (timeout_hit) begin
                    state_d      = StIdle;
                    acc_d        = '0;
                    lock_cnt_d   = '0;
                    hist_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        lock_d = (state_d == StLocked);
    end

    // State and registered outputs; reset clears pulses immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            acc_q        <= '0;
            lock_cnt_q   <= '0;
            to_cnt_q     <= '0;
            div_q        <= 16'(DIV_INIT);
            hist_valid_q <= 1'b0;
            hist_up_q    <= 1'b0;
            add_q        <= 1'b0;
            plus_q       <= 1'b0;
            both_q       <= 1'b0;
            lock_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            lock_cnt_q   <= lock_cnt_d;
            to_cnt_q     <= to_cnt_d;
            div_q        <= div_d;
            hist_valid_q <= hist_valid_d;
            hist_up_q    <= hist_up_d;
            add_q        <= add_d;
            plus_q       <= plus_d;
            both_q       <= both_d;
            lock_q       <= lock_d;
        end
    end

    assign add      = add_q;
    assign plus     = plus_q;
    assign bothedge = both_q;
    assign lock     = lock_q;
    assign div_est  = div_q;

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Directed, table-driven bench for pll_phase_ctrl. A second instance with
// DIV_MAX = 24 shares the stimulus to exercise the divider clamp.
module tb_pll_phase_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        data_in = 1'b0;
    logic        pwm_clk = 1'b0;
    logic        add, plus, bothedge, lock;
    logic [15:0] div_est;
    logic        c_add, c_plus, c_bothedge, c_lock;
    logic [15:0] c_div_est;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pll_phase_ctrl dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .data_in  (data_in),
        .pwm_clk  (pwm_clk),
        .add      (add),
        .plus     (plus),
        .bothedge (bothedge),
        .lock     (lock),
        .div_est  (div_est)
    );

    pll_phase_ctrl #(
        .DIV_MAX (24)
    ) dut_clamp (
        .clk      (clk),
        .reset_n  (reset_n),
        .data_in  (data_in),
        .pwm_clk  (pwm_clk),
        .add      (c_add),
        .plus     (c_plus),
        .bothedge (c_bothedge),
        .lock     (c_lock),
        .div_est  (c_div_est)
    );

    typedef struct {
        bit pwm;
        int e_add;
        int e_plus;
        int e_both;
        int e_div;
        int e_lock;
        int c_add;
        int c_div;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add_vec(input bit pwm, input int e_add, input int e_plus, input int e_both,
                           input int e_div, input int e_lock, input int c_add, input int c_div);
        vec_t v;
        v.pwm = pwm; v.e_add = e_add; v.e_plus = e_plus; v.e_both = e_both;
        v.e_div = e_div; v.e_lock = e_lock; v.c_add = c_add; v.c_div = c_div;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        data_in = 1'b0;
        pwm_clk = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Toggle data_in at a negedge and watch the next four negedges.
    // The pulse for the toggle is expected on the 3rd sample (after edge N+2).
    task automatic apply_edge(input bit pwm, output int n_add, output int n_plus,
                              output int n_both, output int nc_add, output int pulse_at,
                              output int excl);
        n_add = 0; n_plus = 0; n_both = 0; nc_add = 0; pulse_at = 0; excl = 0;
        @(negedge clk);
        data_in = ~data_in;
        pwm_clk = pwm;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            n_add  += int'(add);
            n_plus += int'(plus);
            n_both += int'(bothedge);
            nc_add += int'(c_add);
            if ((add || plus || bothedge) && pulse_at == 0) pulse_at = i;
            if (int'(add) + int'(plus) + int'(bothedge) > 1) excl++;
            if (int'(c_add) + int'(c_plus) + int'(c_bothedge) > 1) excl++;
        end
    endtask

    initial begin
        int n_add, n_plus, n_both, nc_add, pulse_at, excl, k, tot_add, tot_cadd;

        // Resync, 4 early (add), 4 late (plus), 16 alternating (lock),
        // 8 early (two adds: drift; clamp suppresses the 2nd), 16 alternating (relock).
        add_vec(0, 0, 0, 1, 23, 0, 0, 23);
        for (int i = 1; i <= 3; i++) add_vec(0, 0, 0, 0, 23, 0, 0, 23);
        add_vec(0, 1, 0, 0, 24, 0, 1, 24);
        for (int i = 5; i <= 7; i++) add_vec(1, 0, 0, 0, 24, 0, 0, 24);
        add_vec(1, 0, 1, 0, 23, 0, 0, 23);
        for (int i = 9; i <= 24; i++)
            add_vec(((i - 9) % 2) == 1, 0, 0, 0, 23, (i == 24) ? 1 : 0, 0, 23);
        for (int i = 25; i <= 27; i++) add_vec(0, 0, 0, 0, 23, 1, 0, 23);
        add_vec(0, 1, 0, 0, 24, 1, 1, 24);
        for (int i = 29; i <= 31; i++) add_vec(0, 0, 0, 0, 24, 1, 0, 24);
        add_vec(0, 1, 0, 0, 25, 0, 0, 24);
        for (int i = 33; i <= 48; i++)
            add_vec(((i - 33) % 2) == 1, 0, 0, 0, 25, (i == 48) ? 1 : 0, 0, 24);

        do_reset();
        @(negedge clk);
        check("reset add", int'(add), 0);
        check("reset plus", int'(plus), 0);
        check("reset bothedge", int'(bothedge), 0);
        check("reset lock", int'(lock), 0);
        check("reset div_est", int'(div_est), 23);
        check("reset clamp div_est", int'(c_div_est), 23);

        foreach (vecs[i]) begin
            apply_edge(vecs[i].pwm, n_add, n_plus, n_both, nc_add, pulse_at, excl);
            check($sformatf("v%0d add", i), n_add, vecs[i].e_add);
            check($sformatf("v%0d plus", i), n_plus, vecs[i].e_plus);
            check($sformatf("v%0d bothedge", i), n_both, vecs[i].e_both);
            check($sformatf("v%0d div_est", i), int'(div_est), vecs[i].e_div);
            check($sformatf("v%0d lock", i), int'(lock), vecs[i].e_lock);
            check($sformatf("v%0d clamp add", i), nc_add, vecs[i].c_add);
            check($sformatf("v%0d clamp div_est", i), int'(c_div_est), vecs[i].c_div);
            check($sformatf("v%0d clamp lock", i), int'(c_lock), vecs[i].e_lock);
            check($sformatf("v%0d exclusive", i), excl, 0);
            if (vecs[i].e_add + vecs[i].e_plus + vecs[i].e_both > 0)
                check($sformatf("v%0d latency", i), pulse_at, 3);
        end

        // Timeout from LOCKED: sample k sits just after edge E+k, E = last data_edge edge.
        k = 1;
        while (lock === 1'b1 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("timeout cycles", k, 1024);
        check("timeout clamp lock", int'(c_lock), 0);
        apply_edge(1'b0, n_add, n_plus, n_both, nc_add, pulse_at, excl);
        check("post-timeout bothedge", n_both, 1);
        check("post-timeout add", n_add, 0);
        check("post-timeout div_est kept", int'(div_est), 25);
        check("post-timeout clamp div_est kept", int'(c_div_est), 24);

        // Clamp from reset: resync plus 8 early edges.
        do_reset();
        apply_edge(1'b0, n_add, n_plus, n_both, nc_add, pulse_at, excl);
        check("clamp resync bothedge", n_both, 1);
        tot_add = 0;
        tot_cadd = 0;
        for (int i = 0; i < 8; i++) begin
            apply_edge(1'b0, n_add, n_plus, n_both, nc_add, pulse_at, excl);
            tot_add += n_add;
            tot_cadd += nc_add;
        end
        check("clamp add count", tot_cadd, 1);
        check("clamp div_est held", int'(c_div_est), 24);
        check("unclamped add count", tot_add, 2);
        check("unclamped div_est", int'(div_est), 25);

        // Asynchronous reset while an add pulse is high.
        do_reset();
        apply_edge(1'b0, n_add, n_plus, n_both, nc_add, pulse_at, excl);
        for (int i = 0; i < 3; i++) apply_edge(1'b0, n_add, n_plus, n_both, nc_add, pulse_at, excl);
        @(negedge clk);
        data_in = ~data_in;
        pwm_clk = 1'b0;
        repeat (3) @(negedge clk);
        check("pre-reset add high", int'(add), 1);
        check("pre-reset div_est", int'(div_est), 24);
        reset_n = 1'b0;
        #1;
        check("async reset add", int'(add), 0);
        check("async reset div_est", int'(div_est), 23);
        check("async reset clamp add", int'(c_add), 0);
        check("async reset clamp div_est", int'(c_div_est), 23);
        @(negedge clk);
        data_in = 1'b0;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_phase_ctrl.md
# pll_phase_ctrl

Bang-bang phase detector and digital loop filter sitting directly upstream of the PLL's DCO. It compares transitions of the asynchronous `data_in` against the DCO's `pwm_clk` feedback. Filtered votes become single-cycle `add` / `plus` period corrections, plus a `bothedge` counter resync, which drive the DCO. It also keeps a shadow copy of the DCO divider and reports lock.

## Interface

**Parameters**
- `DIV_INIT`, 23: DCO divider reset value; must match the DCO's reset divider.
- `DIV_MIN`, 8: lowest divider allowed; `plus` is suppressed at this value.
- `DIV_MAX`, 64: highest divider allowed; `add` is suppressed at this value.
- `K`, 4: loop-filter threshold, ≥2. A correction fires when the vote accumulator reaches ±K.
- `LOCK_N`, 16: consecutive data edges without a correction needed to declare lock.
- `TIMEOUT`, 1024: number of clk cycles without a data edge before the block returns to IDLE.

**Ports**
- `clk` input 1: system clock; also clocks the DCO.
- `reset_n` input 1: asynchronous, active-low reset.
- `data_in` input 1: asynchronous serial data; both edges are phase references.
- `pwm_clk` input 1: DCO output, synchronous to `clk`.
- `add` output 1: one-cycle pulse; DCO divider +1 (slower).
- `plus` output 1: one-cycle pulse; DCO divider −1 (faster).
- `bothedge` output 1: one-cycle pulse; DCO phase counter resync.
- `lock` output 1: high in LOCKED.
- `div_est` output 16: shadow of the DCO divider.

## Operation

**Edge detection**
- `data_in` passes through a 2-flop synchronizer, s1 then s2.
- s3 holds s2 delayed by one cycle. `data_edge` = s2 ^ s3.

**State machine**
- IDLE:
  - accumulator = 0, lock counter = 0, no votes.
  - On `data_edge`: pulse `bothedge`, go to TRACK. No vote is taken on this edge.
- TRACK, on each `data_edge`, sample `pwm_clk`:
  - `pwm_clk` = 0 is an early vote: acc +1.
  - `pwm_clk` = 1 is a late vote: acc −1.
- LOCKED: votes are taken exactly as in TRACK.

**Loop filter**
- The accumulator is signed, width $clog2(K)+2.
- If the new value equals +K: pulse `add`, clear the accumulator, `div_est` +1.
  - At `div_est` == DIV_MAX, `add` is suppressed and `div_est` is held. The accumulator is still cleared.
- If the new value equals −K: pulse `plus`, clear the accumulator, `div_est` −1.
  - At `div_est` == DIV_MIN, `plus` is suppressed and `div_est` is held. The accumulator is still cleared.
- A suppressed correction counts as a correction for the lock and drift logic.

**Lock**
- Lock counter: +1 per voted data edge that causes no correction. It clears on any correction.
- In TRACK, when the counter reaches LOCK_N: go to LOCKED, `lock` = 1.
- In LOCKED, two consecutive corrections in the same direction mean drift: go to TRACK, `lock` = 0, lock counter cleared.
- Alternating corrections (dither) keep LOCKED.

**Timeout**
- A cycle counter clears on every `data_edge`.
- When it reaches TIMEOUT in TRACK or LOCKED: go to IDLE, `lock` = 0, accumulator and lock counter cleared.
- `div_est` is kept; the DCO is not reset.
- If `data_edge` arrives in the same cycle as the timeout, `data_edge` wins.

**Exclusivity**
- `add`, `plus` and `bothedge` are mutually exclusive in every cycle.

## Timing

**Reset values**
- `add` = `plus` = `bothedge` = 0.
- `lock` = 0.
- `div_est` = DIV_INIT.
- State = IDLE.
- Synchronizer flops, accumulator and all counters = 0.
- Reset takes effect immediately, including mid-correction.

**Latency**
- Take a `data_in` change first captured by s1 at clk edge N.
- `data_edge` is high between edges N+1 and N+2.
- The resulting `add` / `plus` / `bothedge` / `lock` / `div_est` update appears at edge N+2.
- `pwm_clk` is sampled at edge N+2.

**Pulse rules**
- All outputs are registered. Pulses are exactly one clk cycle.
- The minimum spacing between pulses is 2 cycles, the `data_edge` rate limit of the synchronizer.

## Structure

**Package `pll_pkg`**
- State encoding: IDLE, TRACK, LOCKED.
- Shared constant DCO_DIV_INIT = 23. It sets the default of `DIV_INIT` here and of the DCO's reset divider.

**Sub-module `edge_sync`**
- 2-flop synchronizer plus s3 and the XOR edge detector.
- Outputs: `sync_level`, `edge`.
- Reused for other asynchronous inputs in the PLL.

## Test plan

1. **Reset and first edge.** Reset, then `data_in` 0→1, with `pwm_clk` held at 0.
   - Required: `bothedge` pulses once at edge N+2.
   - No `add` / `plus`; `div_est` = 23.
2. **Early drift.** Defaults, after the resync edge: 4 data edges with `pwm_clk` = 0 at each sample.
   - Required: exactly one `add` pulse, on the 4th edge; `div_est` = 24.
   - Then 4 more edges with `pwm_clk` = 1: one `plus`; `div_est` = 23.
3. **Clamp.** DIV_MAX = 24; 8 early edges.
   - Required: one `add` only; `div_est` holds at 24.
   - The second threshold hit is suppressed.
4. **Lock and drift.** Alternate the `pwm_clk` sample per edge for 16 edges.
   - Required: `lock` = 1 after the 16th edge.
   - Then 8 early edges, i.e. two consecutive `add` pulses: `lock` drops to 0 at the 2nd `add`.
5. **Timeout.** TIMEOUT = 1024; stop `data_in` edges while in LOCKED.
   - Required: `lock` = 0 exactly 1024 cycles after the last `data_edge`.
   - The next edge produces `bothedge`.
6. **Asynchronous reset mid-operation.** Assert `reset_n` low in the cycle an `add` pulse is high.
   - Required: `add` = 0 and `div_est` = 23 immediately, without waiting for a clk edge.
